seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div.sv | 114 +++++++++++
 tb/tb_seq_div.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Purpose: N-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: done rises N edges after the start edge (1 edge when the divisor is zero).
// Backpressure: none; starts arriving while busy are dropped, the caller watches busy/done.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   en    - start request, a 0->1 transition starts one division
//   a, b  - dividend / divisor, captured on the start edge only
//   q, r  - registered quotient / remainder
//   busy  - division in progress
//   done  - q/r hold a completed result
//   dbz   - completed result came from a zero divisor (q = all ones, r = a)
module seq_div #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic          en_q;
    logic [N-1:0]  dvd;     // dividend, shifted out MSB first; quotient bits shift in at the LSB
    logic [N-1:0]  dvs;     // captured divisor
    logic [N:0]    rem;     // partial remainder, one spare bit so the shifted value never wraps
    logic [CW-1:0] cnt;

    logic          start;
    logic [N:0]    rem_sh;
    logic [N:0]    rem_nx;
    logic          qbit;
    logic [N-1:0]  quo_nx;

    always_comb begin
        start  = en & ~en_q;
        rem_sh = (rem << 1) | {{N{1'b0}}, dvd[N-1]};
        qbit   = (rem_sh >= {1'b0, dvs});
        rem_nx = qbit ? (rem_sh - {1'b0, dvs}) : rem_sh;
        quo_nx = {dvd[N-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            en_q  <= 1'b0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            en_q <= en;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvd   <= a;
                        dvs   <= b;
                        rem   <= '0;
                        cnt   <= '0;
                        done  <= 1'b0;
                        dbz   <= 1'b0;
                        // A zero divisor spends one quiet cycle in RUN and never raises busy.
                        busy  <= (b != '0);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (dvs == '0) begin
                        q     <= '1;
                        r     <= dvd;
                        dbz   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        rem <= rem_nx;
                        dvd <= quo_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            q     <= quo_nx;
                            r     <= rem_nx[N-1:0];
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    seq_div #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .dbz  (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operands.
    function automatic logic [N-1:0] exp_q(input logic [N-1:0] x, input logic [N-1:0] y);
        if (y == 0) return '1;
        return x / y;
    endfunction

    function automatic logic [N-1:0] exp_r(input logic [N-1:0] x, input logic [N-1:0] y);
        if (y == 0) return x;
        return x % y;
    endfunction

    function automatic int exp_lat(input logic [N-1:0] y);
        return (y == 0) ? 1 : N;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start (en low for one edge, then high), scrambles a/b after the start edge,
    // and reports what was observed. lat = -1 when done never rose within the budget.
    task automatic run_op(input logic [N-1:0] opa, input logic [N-1:0] opb,
                          output int lat, output int busy_cnt, output logic overlap,
                          output logic done_k, output logic dbz_k);
        en = 1'b0;
        tick();
        a  = opa;
        b  = opb;
        en = 1'b1;
        tick();
        done_k   = done;
        dbz_k    = dbz;
        overlap  = busy & done;
        busy_cnt = busy ? 1 : 0;
        lat      = -1;
        a = N'($urandom);
        b = N'($urandom);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        checks++;
        if ({q, r, busy, done, dbz} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     q, r, busy, done, dbz);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [6] = '{4'd14, 4'd15, 4'd3, 4'd7, 4'd0, 4'd15};
        logic [N-1:0] tb [6] = '{4'd3, 4'd1, 4'd5, 4'd0, 4'd9, 4'd15};
        int lat, bc;
        logic ov, dk, zk;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], lat, bc, ov, dk, zk);
            checks++;
            if (lat !== exp_lat(tb[i])) begin
                errors++;
                $display("FAIL dir_latency %0d/%0d: got %0d want %0d", ta[i], tb[i], lat, exp_lat(tb[i]));
            end
            checks++;
            if (q !== exp_q(ta[i], tb[i]) || r !== exp_r(ta[i], tb[i])) begin
                errors++;
                $display("FAIL dir_result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                         ta[i], tb[i], q, r, exp_q(ta[i], tb[i]), exp_r(ta[i], tb[i]));
            end
            checks++;
            if (dbz !== (tb[i] == 0)) begin
                errors++;
                $display("FAIL dir_dbz %0d/%0d: got %b want %b", ta[i], tb[i], dbz, tb[i] == 0);
            end
            checks++;
            if (bc !== ((tb[i] != 0) ? N : 0) || ov !== 1'b0) begin
                errors++;
                $display("FAIL dir_busy %0d/%0d: got busy cycles=%0d overlap=%b want %0d 0",
                         ta[i], tb[i], bc, ov, (tb[i] != 0) ? N : 0);
            end
            checks++;
            if (dk !== 1'b0 || zk !== 1'b0) begin
                errors++;
                $display("FAIL dir_start_clears %0d/%0d: got done=%b dbz=%b want 0 0", ta[i], tb[i], dk, zk);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ra, rb;
        int lat, bc;
        logic ov, dk, zk;
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom_range(0, 15));
            rb = N'($urandom_range(0, 15));
            run_op(ra, rb, lat, bc, ov, dk, zk);
            checks++;
            if (lat !== exp_lat(rb) || q !== exp_q(ra, rb) || r !== exp_r(ra, rb) || dbz !== (rb == 0)) begin
                errors++;
                $display("FAIL rand_op %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=%0d r=%0d dbz=%b",
                         ra, rb, lat, q, r, dbz, exp_lat(rb), exp_q(ra, rb), exp_r(ra, rb), rb == 0);
            end
            checks++;
            if (bc !== ((rb != 0) ? N : 0) || ov !== 1'b0 || dk !== 1'b0 || zk !== 1'b0) begin
                errors++;
                $display("FAIL rand_ctrl %0d/%0d: got busy cycles=%0d overlap=%b done_k=%b dbz_k=%b",
                         ra, rb, bc, ov, dk, zk);
            end
        end
    endtask

    // en toggles 1->0->1 and operands change while the division runs.
    task automatic test_en_ignore();
        en = 1'b0;
        tick();
        a  = 4'd15;
        b  = 4'd14;
        en = 1'b1;
        tick();                 // start edge k
        en = 1'b0;
        a  = 4'd3;
        b  = 4'd0;
        tick();                 // k+1
        en = 1'b1;
        a  = 4'd0;
        b  = 4'd7;
        tick();                 // k+2
        tick();                 // k+3
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ign_running: got busy=%b done=%b want 1 0", busy, done);
        end
        tick();                 // k+4
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== exp_q(4'd15, 4'd14) || r !== exp_r(4'd15, 4'd14) || dbz !== 1'b0) begin
            errors++;
            $display("FAIL ign_result: got done=%b busy=%b q=%0d r=%0d dbz=%b want 1 0 1 1 0",
                     done, busy, q, r, dbz);
        end
    endtask

    // en stays high in DONE: result must hold; a fresh 0->1 restarts.
    task automatic test_done_hold();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            tick();
            if (done !== 1'b1 || busy !== 1'b0 || q !== 4'd1 || r !== 4'd1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0 (last q=%0d r=%0d done=%b busy=%b)",
                     bad, q, r, done, busy);
        end
        en = 1'b0;
        tick();
        a  = 4'd12;
        b  = 4'd5;
        en = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || q !== 4'd1 || r !== 4'd1) begin
            errors++;
            $display("FAIL restart_edge: got done=%b busy=%b q=%0d r=%0d want 0 1 1 1", done, busy, q, r);
        end
        repeat (N) tick();
        checks++;
        if (done !== 1'b1 || q !== exp_q(4'd12, 4'd5) || r !== exp_r(4'd12, 4'd5)) begin
            errors++;
            $display("FAIL restart_result: got done=%b q=%0d r=%0d want 1 %0d %0d",
                     done, q, r, exp_q(4'd12, 4'd5), exp_r(4'd12, 4'd5));
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        logic ov, dk, zk;
        en = 1'b0;
        tick();
        a  = 4'd13;
        b  = 4'd2;
        en = 1'b1;
        tick();                 // start edge
        tick();
        tick();                 // two edges into RUN
        rst_n = 1'b0;
        #1;
        checks++;
        if ({q, r, busy, done, dbz} !== '0) begin
            errors++;
            $display("FAIL abort_immediate: got q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
                     q, r, busy, done, dbz);
        end
        en = 1'b0;
        tick();
        tick();
        checks++;
        if ({q, r, busy, done, dbz} !== '0) begin
            errors++;
            $display("FAIL abort_held: got q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
                     q, r, busy, done, dbz);
        end
        rst_n = 1'b1;
        run_op(4'd9, 4'd2, lat, bc, ov, dk, zk);
        checks++;
        if (lat !== N || q !== 4'd4 || r !== 4'd1) begin
            errors++;
            $display("FAIL abort_fresh: got lat=%0d q=%0d r=%0d want %0d 4 1", lat, q, r, N);
        end
    endtask

    // en already high when reset releases: the first edge is a start.
    task automatic test_reset_en_high();
        rst_n = 1'b0;
        en    = 1'b1;
        a     = 4'd11;
        b     = 4'd4;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rel_start: got busy=%b want 1", busy);
        end
        repeat (N - 1) tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rel_early: got done=%b want 0", done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || q !== exp_q(4'd11, 4'd4) || r !== exp_r(4'd11, 4'd4)) begin
            errors++;
            $display("FAIL rel_result: got done=%b q=%0d r=%0d want 1 %0d %0d",
                     done, q, r, exp_q(4'd11, 4'd4), exp_r(4'd11, 4'd4));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_directed();
        test_random();
        test_en_ignore();
        test_done_hold();
        test_reset_abort();
        test_reset_en_high();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
